// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Sub-word stores use read-modify-write; bad requests get an error response with no memory write.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  localparam logic [31:0] LP_MEM_BYTES = 32'(MEM_BYTES);
  localparam logic [1:0]  LP_BYTE      = 2'b00;
  localparam logic [1:0]  LP_HALF      = 2'b01;
  localparam logic [1:0]  LP_WORD      = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_raddr;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_err;
  logic        w_word_store;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept     = req_valid & req_ready;
  assign w_word_store = req_write & (req_size == LP_WORD);
  assign w_err        = (req_size == 2'b11)
                      | ((req_size == LP_HALF) & req_addr[0])
                      | ((req_size == LP_WORD) & (req_addr[1:0] != 2'b00))
                      | (req_addr >= LP_MEM_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_err)             w_state_next = S_RESP;
          else if (w_word_store) w_state_next = S_WR;
          else                   w_state_next = S_RD;
        end
      end
      S_RD:   w_state_next = r_write ? S_WR : S_RESP;
      S_WR: begin
        mem_we       = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Little-endian lane extraction from the word addressed by r_mem_raddr.
  assign w_rd_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_rd_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = mem_rdata;
    case (r_size)
      LP_BYTE: w_load_data = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
      LP_HALF: w_load_data = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LP_LANE = 2'(gi);
      logic w_hit;
      logic [7:0] w_new;
      assign w_hit = (r_size == LP_BYTE) ? (r_lane == LP_LANE) : (r_lane[1] == LP_LANE[1]);
      // The upper byte of a half store lands in the odd lane of the pair.
      assign w_new = ((r_size == LP_HALF) && LP_LANE[0]) ? r_wdata[15:8] : r_wdata[7:0];
      assign w_merged[8*gi +: 8] = w_hit ? w_new : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_raddr  <= '0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata[15:0];
            r_mem_raddr <= {req_addr[31:2], 2'b00};
            if (w_err) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (w_word_store) begin
              r_mem_waddr <= {req_addr[31:2], 2'b00};
              r_mem_wdata <= req_wdata;
            end
          end
        end
        S_RD: begin
          if (r_write) begin
            r_mem_waddr <= r_mem_raddr;
            r_mem_wdata <= w_merged;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= 1'b0;
          end
        end
        S_WR: begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_raddr  = r_mem_raddr;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;

endmodule
